// File: rtl/card_deal_arbiter.sv
// -----------------------------------------------------------------------------
// card_deal_arbiter
//
// Shares one card deck between the player and dealer hand controllers. Level
// draw requests from both hands are arbitrated round-robin. Each grant issues
// a single draw pulse to the deck, waits a bounded time for the deck's valid
// handshake, and routes the returned card to exactly one hand with an ack.
// Per-hand card counts are kept so a full hand can no longer draw.
//
// Ports:
//   i_clk          clock
//   i_reset        asynchronous, active-high reset
//   i_playerReq    player draw request (level, held until o_playerAck)
//   i_dealerReq    dealer draw request (level, held until o_dealerAck)
//   i_newRound     one-cycle pulse: clears both counts and the timeout error
//   i_deckReady    deck idle / not shuffling; grants only happen while high
//   o_deckDraw     one-cycle draw pulse to the deck
//   i_deckValid    one-cycle pulse qualifying i_deckCard
//   i_deckCard     card value from the deck
//   o_card         last delivered card, meaningful with an ack
//   o_playerAck    one-cycle pulse: o_card belongs to the player
//   o_dealerAck    one-cycle pulse: o_card belongs to the dealer
//   o_playerCount  cards delivered to the player this round
//   o_dealerCount  cards delivered to the dealer this round
//   o_playerFull   player count has reached MAX_CARDS
//   o_dealerFull   dealer count has reached MAX_CARDS
//   o_busy         arbiter is not idle
//   o_timeoutErr   sticky deck-timeout flag, cleared by i_newRound
// -----------------------------------------------------------------------------
module card_deal_arbiter #(
  parameter int CARD_W       = 6,
  parameter int MAX_CARDS    = 5,
  parameter int DECK_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_playerReq,
  input  logic              i_dealerReq,
  input  logic              i_newRound,
  input  logic              i_deckReady,
  output logic              o_deckDraw,
  input  logic              i_deckValid,
  input  logic [CARD_W-1:0] i_deckCard,
  output logic [CARD_W-1:0] o_card,
  output logic              o_playerAck,
  output logic              o_dealerAck,
  output logic [2:0]        o_playerCount,
  output logic [2:0]        o_dealerCount,
  output logic              o_playerFull,
  output logic              o_dealerFull,
  output logic              o_busy,
  output logic              o_timeoutErr
);

  // The timer only has to hold 0 .. DECK_TIMEOUT-1.
  localparam int TIMER_W = (DECK_TIMEOUT > 1) ? $clog2(DECK_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DECK_TIMEOUT - 1);
  localparam logic [2:0]         COUNT_MAX  = 3'(MAX_CARDS);

  localparam logic HAND_DEALER = 1'b0;
  localparam logic HAND_PLAYER = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DELIVER = 3'd3,
    ST_GAP     = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic                winner_r, winner_s;   // hand owning the transaction
  logic                last_r, last_s;       // hand served most recently
  logic [TIMER_W-1:0]  timer_r, timer_s;
  logic [CARD_W-1:0]   card_r, card_s;
  logic [2:0]          player_count_r, player_count_s;
  logic [2:0]          dealer_count_r, dealer_count_s;

  logic                deck_draw_r;
  logic                player_ack_r;
  logic                dealer_ack_r;
  logic                player_full_r;
  logic                dealer_full_r;
  logic                busy_r;
  logic                timeout_err_r;

  logic                player_full_s;
  logic                dealer_full_s;
  logic                player_elig_s;
  logic                dealer_elig_s;
  logic                any_elig_s;
  logic                grant_s;

  // Saturating card counter step; a full hand never wraps back to zero.
  function automatic logic [2:0] sat_inc(input logic [2:0] count);
    logic [2:0] result;
    if (count == COUNT_MAX) begin
      result = count;
    end else begin
      result = count + 3'd1;
    end
    return result;
  endfunction

  // Eligibility: a request counts only while its hand still has room.
  always_comb begin
    player_full_s = (player_count_r == COUNT_MAX);
    dealer_full_s = (dealer_count_r == COUNT_MAX);
    player_elig_s = i_playerReq & ~player_full_s;
    dealer_elig_s = i_dealerReq & ~dealer_full_s;
    any_elig_s    = player_elig_s | dealer_elig_s;
  end

  // Round-robin pick: on a tie the hand not served last wins.
  always_comb begin
    grant_s = HAND_DEALER;
    if (player_elig_s && dealer_elig_s) begin
      grant_s = (last_r == HAND_PLAYER) ? HAND_DEALER : HAND_PLAYER;
    end else if (player_elig_s) begin
      grant_s = HAND_PLAYER;
    end else begin
      grant_s = HAND_DEALER;
    end
  end

  // Next-state logic for the deal sequencer and its datapath registers.
  always_comb begin
    state_s  = state_r;
    winner_s = winner_r;
    last_s   = last_r;
    timer_s  = timer_r;
    card_s   = card_r;
    case (state_r)
      ST_IDLE: begin
        if (any_elig_s && i_deckReady) begin
          winner_s = grant_s;
          state_s  = ST_ISSUE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        timer_s = '0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A card on the final timer value still counts as on time.
        if (i_deckValid) begin
          card_s  = i_deckCard;
          state_s = ST_DELIVER;
        end else if (timer_r == TIMER_LAST) begin
          state_s = ST_ERROR;
        end else begin
          timer_s = timer_r + TIMER_W'(1);
          state_s = ST_WAIT;
        end
      end
      ST_DELIVER: begin
        last_s  = winner_r;
        state_s = ST_GAP;
      end
      ST_GAP: begin
        // Lets the served hand drop its request before the next decision.
        state_s = ST_IDLE;
      end
      ST_ERROR: begin
        if (i_newRound) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ERROR;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Card counts: a new round clears them and beats a same-cycle increment.
  always_comb begin
    player_count_s = player_count_r;
    dealer_count_s = dealer_count_r;
    if (i_newRound) begin
      player_count_s = 3'd0;
      dealer_count_s = 3'd0;
    end else if (state_r == ST_DELIVER) begin
      if (winner_r == HAND_PLAYER) begin
        player_count_s = sat_inc(player_count_r);
      end else begin
        dealer_count_s = sat_inc(dealer_count_r);
      end
    end else begin
      player_count_s = player_count_r;
      dealer_count_s = dealer_count_r;
    end
  end

  // State and datapath registers. Dealer is dealt first, so the pointer
  // starts out as if the player had just been served.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r        <= ST_IDLE;
      winner_r       <= HAND_DEALER;
      last_r         <= HAND_PLAYER;
      timer_r        <= '0;
      card_r         <= '0;
      player_count_r <= 3'd0;
      dealer_count_r <= 3'd0;
    end else begin
      state_r        <= state_s;
      winner_r       <= winner_s;
      last_r         <= last_s;
      timer_r        <= timer_s;
      card_r         <= card_s;
      player_count_r <= player_count_s;
      dealer_count_r <= dealer_count_s;
    end
  end

  // Output registers, decoded from the next state so they line up exactly
  // with the state they describe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      deck_draw_r   <= 1'b0;
      player_ack_r  <= 1'b0;
      dealer_ack_r  <= 1'b0;
      player_full_r <= 1'b0;
      dealer_full_r <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      deck_draw_r   <= (state_s == ST_ISSUE);
      player_ack_r  <= (state_s == ST_DELIVER) && (winner_s == HAND_PLAYER);
      dealer_ack_r  <= (state_s == ST_DELIVER) && (winner_s == HAND_DEALER);
      player_full_r <= (player_count_s == COUNT_MAX);
      dealer_full_r <= (dealer_count_s == COUNT_MAX);
      busy_r        <= (state_s != ST_IDLE);
      timeout_err_r <= (state_s == ST_ERROR);
    end
  end

  assign o_deckDraw    = deck_draw_r;
  assign o_card        = card_r;
  assign o_playerAck   = player_ack_r;
  assign o_dealerAck   = dealer_ack_r;
  assign o_playerCount = player_count_r;
  assign o_dealerCount = dealer_count_r;
  assign o_playerFull  = player_full_r;
  assign o_dealerFull  = dealer_full_r;
  assign o_busy        = busy_r;
  assign o_timeoutErr  = timeout_err_r;

endmodule

// File: tb/tb_card_deal_arbiter.sv
// -----------------------------------------------------------------------------
// tb_card_deal_arbiter
//
// Directed bench for card_deal_arbiter. A timeline model (grant time, card
// arrival time, per-hand counts) predicts every output each cycle and is
// compared on the falling edge; directed sequences add literal checks.
// -----------------------------------------------------------------------------
module tb_card_deal_arbiter;

  localparam int CARD_W       = 6;
  localparam int MAX_CARDS    = 5;
  localparam int DECK_TIMEOUT = 16;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_playerReq = 1'b0;
  logic              i_dealerReq = 1'b0;
  logic              i_newRound = 1'b0;
  logic              i_deckReady = 1'b0;
  logic              o_deckDraw;
  logic              i_deckValid = 1'b0;
  logic [CARD_W-1:0] i_deckCard = '0;
  logic [CARD_W-1:0] o_card;
  logic              o_playerAck;
  logic              o_dealerAck;
  logic [2:0]        o_playerCount;
  logic [2:0]        o_dealerCount;
  logic              o_playerFull;
  logic              o_dealerFull;
  logic              o_busy;
  logic              o_timeoutErr;

  card_deal_arbiter #(
    .CARD_W(CARD_W), .MAX_CARDS(MAX_CARDS), .DECK_TIMEOUT(DECK_TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_playerReq(i_playerReq), .i_dealerReq(i_dealerReq),
    .i_newRound(i_newRound), .i_deckReady(i_deckReady),
    .o_deckDraw(o_deckDraw), .i_deckValid(i_deckValid), .i_deckCard(i_deckCard),
    .o_card(o_card), .o_playerAck(o_playerAck), .o_dealerAck(o_dealerAck),
    .o_playerCount(o_playerCount), .o_dealerCount(o_dealerCount),
    .o_playerFull(o_playerFull), .o_dealerFull(o_dealerFull),
    .o_busy(o_busy), .o_timeoutErr(o_timeoutErr)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline reference model ----------------
  int          cyc;
  bit          m_txn, m_err, m_hand, m_last;  // m_hand/m_last: 1 = player
  int          m_grant, m_valid, m_pc, m_dc, m_age;
  logic [CARD_W-1:0] m_card;
  bit          m_pe, m_de;
  bit          e_draw, e_pack, e_dack, e_busy, e_err;

  initial forever begin
    @(posedge i_clk or posedge i_reset);
    if (i_reset) begin
      cyc = 0; m_txn = 0; m_err = 0; m_hand = 0; m_last = 1;
      m_grant = 0; m_valid = -1; m_pc = 0; m_dc = 0; m_card = '0;
      e_draw = 0; e_pack = 0; e_dack = 0; e_busy = 0; e_err = 0;
    end else begin
      m_pe = i_playerReq && (m_pc < MAX_CARDS);
      m_de = i_dealerReq && (m_dc < MAX_CARDS);
      if (m_err) begin
        if (i_newRound) m_err = 0;
      end else if (!m_txn) begin
        if ((m_pe || m_de) && i_deckReady) begin
          m_txn = 1; m_grant = cyc; m_valid = -1;
          m_hand = (m_pe && m_de) ? !m_last : m_pe;
        end
      end else begin
        m_age = cyc - m_grant;  // 1 = draw cycle, 2.. = waiting for card
        if (m_valid < 0) begin
          if (m_age >= 2) begin
            if (i_deckValid) begin
              m_valid = cyc; m_card = i_deckCard;
            end else if (m_age == DECK_TIMEOUT + 1) begin
              m_err = 1; m_txn = 0;
            end
          end
        end else if (cyc == m_valid + 1) begin
          if (m_hand) m_pc = (m_pc < MAX_CARDS) ? m_pc + 1 : m_pc;
          else        m_dc = (m_dc < MAX_CARDS) ? m_dc + 1 : m_dc;
          m_last = m_hand;
        end else if (cyc == m_valid + 2) begin
          m_txn = 0;
        end
      end
      if (i_newRound) begin m_pc = 0; m_dc = 0; end
      cyc++;
      e_draw = m_txn && (cyc - m_grant == 1);
      e_pack = m_txn && (m_valid >= 0) && (cyc == m_valid + 1) && m_hand;
      e_dack = m_txn && (m_valid >= 0) && (cyc == m_valid + 1) && !m_hand;
      e_busy = m_txn || m_err;
      e_err  = m_err;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      chk("draw", o_deckDraw, e_draw);
      chk("player_ack", o_playerAck, e_pack);
      chk("dealer_ack", o_dealerAck, e_dack);
      chk("busy", o_busy, e_busy);
      chk("timeout_err", o_timeoutErr, e_err);
      chk("player_count", o_playerCount, m_pc);
      chk("dealer_count", o_dealerCount, m_dc);
      chk("player_full", o_playerFull, m_pc == MAX_CARDS);
      chk("dealer_full", o_dealerFull, m_dc == MAX_CARDS);
      chk("card", o_card, m_card);
    end
  end

  // ---------------- deck responder ----------------
  int                deck_pend = 0;
  int                deck_lat = 1;     // cycles from draw to valid
  bit                deck_mute = 0;
  logic [CARD_W-1:0] deck_card = 6'h2A;

  initial forever begin
    @(negedge i_clk);
    i_deckValid = 1'b0;
    i_deckCard  = ~deck_card;          // noise outside valid
    if (deck_pend > 0) begin
      deck_pend--;
      if (deck_pend == 0) begin
        i_deckValid = 1'b1;
        i_deckCard  = deck_card;
      end
    end
    if (o_deckDraw && !deck_mute) deck_pend = deck_lat;
  end

  // ---------------- helpers ----------------
  bit  ack_order[$];   // 1 = player
  time draw_t[$];

  task automatic do_reset();
    @(negedge i_clk); #2 i_reset = 1'b1;
    @(negedge i_clk); #2 i_reset = 1'b0;
  endtask

  task automatic run_acks(input int n, input int budget, input bit drop);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge i_clk);
      if (o_deckDraw) draw_t.push_back($time);
      if (o_playerAck || o_dealerAck) begin
        ack_order.push_back(o_playerAck);
        got++;
        if (got == n && drop) begin i_playerReq = 1'b0; i_dealerReq = 1'b0; end
      end
    end
    chk("ack_budget", got, n);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      if (o_deckDraw) draw_t.push_back($time);
    end
  endtask

  task automatic wait_draw(input string nm);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge i_clk);
      if (o_deckDraw) found = 1;
    end
    chk(nm, found, 1);
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    int busy_seen;
    int acks;
    bit found;

    repeat (3) @(negedge i_clk);
    #2 i_reset = 1'b0; chk_en = 1'b1;
    chk("rst_draw", o_deckDraw, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_card", o_card, 0);
    chk("rst_counts", o_playerCount + o_dealerCount, 0);
    chk("rst_err", o_timeoutErr, 0);

    // Single dealer draw, card 2A one cycle after the draw pulse.
    i_deckReady = 1'b1; deck_lat = 1; deck_card = 6'h2A;
    @(negedge i_clk); i_dealerReq = 1'b1;               // cycle N
    @(negedge i_clk); chk("t1_draw_n1", o_deckDraw, 1);
    @(negedge i_clk); chk("t1_noack_n2", o_dealerAck, 0);
    @(negedge i_clk); chk("t1_ack_n3", o_dealerAck, 1);
    chk("t1_card", o_card, 6'h2A);
    i_dealerReq = 1'b0;
    @(negedge i_clk);
    chk("t1_dealer_count", o_dealerCount, 1);
    chk("t1_player_count", o_playerCount, 0);

    // Both hands held: strict alternation starting with the dealer.
    do_reset();
    deck_card = 6'h11; ack_order.delete(); draw_t.delete();
    i_playerReq = 1'b1; i_dealerReq = 1'b1;
    run_acks(4, 200, 1'b1);
    idle_cycles(12);
    chk("t2_draws", draw_t.size(), 4);
    if (ack_order.size() == 4) begin
      chk("t2_order0", ack_order[0], 0);
      chk("t2_order1", ack_order[1], 1);
      chk("t2_order2", ack_order[2], 0);
      chk("t2_order3", ack_order[3], 1);
    end
    for (int i = 1; i < draw_t.size(); i++)
      chk("t2_spacing_ge4", (draw_t[i] - draw_t[i-1]) >= 40, 1);
    chk("t2_player_count", o_playerCount, 2);
    chk("t2_dealer_count", o_dealerCount, 2);

    // Deck not ready: nothing happens until it rises.
    do_reset();
    deck_card = 6'h05; draw_t.delete(); busy_seen = 0;
    i_deckReady = 1'b0; i_playerReq = 1'b1; i_dealerReq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_deckDraw) draw_t.push_back($time);
      busy_seen += o_busy;
    end
    chk("t4_no_draw", draw_t.size(), 0);
    chk("t4_no_busy", busy_seen, 0);
    i_deckReady = 1'b1;
    @(negedge i_clk); chk("t4_draw_next", o_deckDraw, 1);
    ack_order.delete();
    run_acks(1, 50, 1'b1);
    if (ack_order.size() == 1) chk("t4_dealer_first", ack_order[0], 0);
    idle_cycles(4);

    // Player held past the hand limit.
    do_reset();
    deck_card = 6'h33; draw_t.delete();
    i_playerReq = 1'b1;
    run_acks(MAX_CARDS, 300, 1'b0);
    idle_cycles(30);
    chk("t3_draws", draw_t.size(), 5);
    chk("t3_full", o_playerFull, 1);
    chk("t3_count", o_playerCount, 5);

    // Deck never answers: timeout, error sticks, new round recovers.
    deck_mute = 1; i_dealerReq = 1'b1;
    wait_draw("t5_draw_seen");
    repeat (16) @(negedge i_clk);
    chk("t5_err_not_yet", o_timeoutErr, 0);
    @(negedge i_clk);
    chk("t5_err_set", o_timeoutErr, 1);
    draw_t.delete();
    idle_cycles(10);
    chk("t5_no_draw_in_err", draw_t.size(), 0);
    chk("t5_err_sticky", o_timeoutErr, 1);
    deck_mute = 0; deck_card = 6'h1C;
    i_newRound = 1'b1;
    @(negedge i_clk); i_newRound = 1'b0;
    chk("t5_err_clear", o_timeoutErr, 0);
    chk("t5_idle", o_busy, 0);
    chk("t5_pcount", o_playerCount, 0);
    chk("t5_dcount", o_dealerCount, 0);
    ack_order.delete();
    run_acks(1, 50, 1'b1);
    if (ack_order.size() == 1) chk("t5_serviced_dealer", ack_order[0], 0);
    idle_cycles(4);

    // New round landing on a dealer delivery with count 3.
    do_reset();
    deck_lat = 1; deck_card = 6'h27;
    i_dealerReq = 1'b1;
    run_acks(3, 100, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_clk);
      if (o_dealerAck) begin
        found = 1;
        chk("t6_count_before", o_dealerCount, 3);
        i_newRound = 1'b1;
      end
    end
    chk("t6_ack_seen", found, 1);
    @(negedge i_clk); i_newRound = 1'b0; i_dealerReq = 1'b0;
    chk("t6_count_cleared", o_dealerCount, 0);
    chk("t6_card", o_card, 6'h27);

    // Reset while waiting for the deck; the late card is ignored.
    deck_lat = 3; deck_card = 6'h3A;
    @(negedge i_clk); i_dealerReq = 1'b1;
    wait_draw("t6_draw_seen");
    @(negedge i_clk);
    #2 i_dealerReq = 1'b0; i_reset = 1'b1;
    #1;
    chk("t6r_busy", o_busy, 0);
    chk("t6r_draw", o_deckDraw, 0);
    chk("t6r_card", o_card, 0);
    chk("t6r_acks", o_playerAck + o_dealerAck, 0);
    chk("t6r_err", o_timeoutErr, 0);
    @(negedge i_clk); #2 i_reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      acks += o_playerAck + o_dealerAck;
    end
    chk("t6r_late_valid_no_ack", acks, 0);
    chk("t6r_card_still_0", o_card, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
